// File: rtl/serial_parity_checker_pkg.sv
// rtl/serial_parity_checker_pkg.sv - shared state encoding and frame constants for the serial parity checker
package serial_parity_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_HOLD   = 2'd3
   } state_e;

   localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/serial_parity_checker_xor_accumulator.sv
// rtl/serial_parity_checker_xor_accumulator.sv - single-flop running XOR of accepted data bits
module xor_accumulator (
   input  logic clock,
   input  logic reset_,
   input  logic clr,
   input  logic en,
   input  logic d,
   output logic q
);

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         q <= 1'b0;
      end else if (clr) begin
         q <= 1'b0;
      end else if (en) begin
         q <= q ^ d;
      end
   end

endmodule

// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - serial frame receiver: start bit, LSB-first data, parity bit, held result
module serial_parity_checker
   import serial_parity_checker_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                 clock,
   input  logic                 reset_,
   input  logic                 bit_in,
   input  logic                 bit_valid,
   output logic                 bit_ready,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 parity_err,
   output logic                 done,
   input  logic                 res_ack
);

   localparam int CW = $clog2(DATA_BITS);

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 perr_q, perr_d;
   logic                 acc_q, acc_clr, acc_en;
   logic                 accept;

   // Ready depends on state alone so the source never sees a combinational loop.
   assign bit_ready  = (state_q != ST_HOLD);
   assign accept     = bit_valid && bit_ready;
   assign done       = (state_q == ST_HOLD);
   assign data_out   = data_q;
   assign parity_err = perr_q;

   xor_accumulator u_acc (
      .clock  (clock),
      .reset_ (reset_),
      .clr    (acc_clr),
      .en     (acc_en),
      .d      (bit_in),
      .q      (acc_q)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      perr_d  = perr_q;
      acc_clr = 1'b0;
      acc_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept && (bit_in == START_BIT)) begin
               state_d = ST_DATA;
               cnt_d   = '0;
               acc_clr = 1'b1;
            end
         end
         ST_DATA: begin
            if (accept) begin
               shreg_d = {bit_in, shreg_q[DATA_BITS-1:1]};
               acc_en  = 1'b1;
               if (cnt_q == CW'(DATA_BITS - 1)) begin
                  cnt_d   = '0;
                  state_d = ST_PARITY;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (accept) begin
               perr_d  = acc_q ^ bit_in ^ PARITY_ODD;
               data_d  = shreg_q;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (res_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         perr_q  <= perr_d;
      end
   end

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb/tb_serial_parity_checker.sv - self-checking bench for even and odd parity variants of the checker
module tb_serial_parity_checker;

   logic       clock = 1'b0;
   logic       reset_;
   logic       bit_in;
   logic       bit_valid;
   logic       res_ack;
   logic       ready_e, perr_e, done_e;
   logic       ready_o, perr_o, done_o;
   logic [7:0] data_e, data_o;

   always #5 clock = ~clock;

   serial_parity_checker #(.DATA_BITS(8), .PARITY_ODD(1'b0)) dut_even (
      .clock      (clock),
      .reset_     (reset_),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .bit_ready  (ready_e),
      .data_out   (data_e),
      .parity_err (perr_e),
      .done       (done_e),
      .res_ack    (res_ack)
   );

   serial_parity_checker #(.DATA_BITS(8), .PARITY_ODD(1'b1)) dut_odd (
      .clock      (clock),
      .reset_     (reset_),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .bit_ready  (ready_o),
      .data_out   (data_o),
      .parity_err (perr_o),
      .done       (done_o),
      .res_ack    (res_ack)
   );

   typedef struct {
      logic [7:0] data;
      logic       par;
      int         idle_ones;
      bit         gaps;
      bit         hold_test;
      logic [7:0] exp_data;
      logic       exp_perr_even;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       perr_even;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   done_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_bit(input logic b);
      check("ready_before_bit", {31'd0, ready_e}, 32'd1);
      bit_in    = b;
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
   endtask

   task automatic gap(input bit en);
      if (en) repeat ($urandom_range(1, 3)) tick();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input bit gaps,
                             input logic [7:0] exp_d, input logic exp_p);
      exp_t e;
      e.data      = exp_d;
      e.perr_even = exp_p;
      sb.push_back(e);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         gap(gaps);
         send_bit(d[i]);
      end
      gap(gaps);
      check("done_before_parity", {31'd0, done_e}, 32'd0);
      send_bit(p);
      check("done_after_parity", {31'd0, done_e}, 32'd1);
   endtask

   task automatic ack();
      res_ack = 1'b1;
      tick();
      res_ack = 1'b0;
      check("done_after_ack", {31'd0, done_e}, 32'd0);
      check("ready_after_ack", {31'd0, ready_e}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_done"},  {31'd0, done_e},  32'd0);
      check({tag, "_ready"}, {31'd0, ready_e}, 32'd1);
      check({tag, "_data"},  {24'd0, data_e},  32'd0);
      check({tag, "_perr"},  {31'd0, perr_e},  32'd0);
      check({tag, "_data_odd"}, {24'd0, data_o}, 32'd0);
      check({tag, "_done_odd"}, {31'd0, done_o}, 32'd0);
   endtask

   // Scoreboard: each rising done pops the oldest expected frame.
   always @(negedge clock) begin
      if (reset_ && done_e && !done_seen) begin
         done_seen = 1'b1;
         if (sb.size() == 0) begin
            check("sb_unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_data_even", {24'd0, data_e}, {24'd0, e.data});
            check("sb_perr_even", {31'd0, perr_e}, {31'd0, e.perr_even});
            check("sb_data_odd",  {24'd0, data_o}, {24'd0, e.data});
            check("sb_perr_odd",  {31'd0, perr_o}, {31'd0, ~e.perr_even});
            check("sb_done_odd",  {31'd0, done_o}, 32'd1);
         end
      end else if (!done_e) begin
         done_seen = 1'b0;
      end
   end

   initial begin
      logic [7:0] held_data;
      logic       held_perr;

      vecs.push_back('{8'hA5, 1'b0, 0, 1'b0, 1'b0, 8'hA5, 1'b0});
      vecs.push_back('{8'hA5, 1'b1, 0, 1'b0, 1'b0, 8'hA5, 1'b1});
      vecs.push_back('{8'h3C, 1'b0, 5, 1'b1, 1'b1, 8'h3C, 1'b0});
      vecs.push_back('{8'h00, 1'b1, 0, 1'b0, 1'b0, 8'h00, 1'b1});
      vecs.push_back('{8'h00, 1'b0, 0, 1'b0, 1'b0, 8'h00, 1'b0});
      vecs.push_back('{8'hFF, 1'b0, 2, 1'b1, 1'b0, 8'hFF, 1'b0});
      vecs.push_back('{8'h81, 1'b1, 0, 1'b0, 1'b0, 8'h81, 1'b1});

      reset_    = 1'b0;
      bit_in    = 1'b1;
      bit_valid = 1'b0;
      res_ack   = 1'b0;
      repeat (2) tick();
      reset_ = 1'b1;
      tick();
      check_reset_outputs("reset");

      // Stray ack while idle must not disturb anything.
      res_ack = 1'b1;
      tick();
      res_ack = 1'b0;
      check("idle_ack_done", {31'd0, done_e}, 32'd0);

      foreach (vecs[i]) begin
         repeat (vecs[i].idle_ones) send_bit(1'b1);
         check("idle_ones_ignored", {31'd0, done_e}, 32'd0);
         send_frame(vecs[i].data, vecs[i].par, vecs[i].gaps,
                    vecs[i].exp_data, vecs[i].exp_perr_even);
         if (vecs[i].hold_test) begin
            held_data = data_e;
            held_perr = perr_e;
            for (int c = 0; c < 6; c++) begin
               bit_in    = c[0];
               bit_valid = 1'b1;
               check("hold_ready", {31'd0, ready_e}, 32'd0);
               tick();
               check("hold_done", {31'd0, done_e}, 32'd1);
               check("hold_data", {24'd0, data_e}, {24'd0, held_data});
               check("hold_perr", {31'd0, perr_e}, {31'd0, held_perr});
            end
            bit_valid = 1'b0;
         end
         ack();
         check("data_kept_after_ack", {24'd0, data_e}, {24'd0, vecs[i].exp_data});
      end

      // Asynchronous reset mid-frame, applied between clock edges.
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      #2 reset_ = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      tick();
      reset_ = 1'b1;
      tick();
      send_frame(8'h81, 1'b0, 1'b0, 8'h81, 1'b0);
      ack();

      repeat (3) tick();
      check("sb_empty", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
